// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_arbiter
//  Purpose  : Single-port framebuffer sharing between display scan-out and a
//             host read/write port, with sync/video delay alignment.
//  Revision : 1.0
// ============================================================================
module fb_arbiter #(
   parameter int DW          = 8,
   parameter int AW          = 17,
   parameter int H_ACT       = 640,
   parameter int V_ACT       = 480,
   parameter int SCALE_SHIFT = 1,
   parameter int FB_WORDS    = 76800
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          p_tick,
   input  logic          video_on,
   input  logic          hsync_i,
   input  logic          vsync_i,
   input  logic [9:0]    pixel_x,
   input  logic [9:0]    pixel_y,
   input  logic          vblank_only,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   output logic          host_rvalid,
   output logic          host_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          hsync,
   output logic          vsync,
   output logic [DW-1:0] rgb,
   output logic          frame_start
);

   localparam logic [1:0]    c_TAG_NONE   = 2'd0;
   localparam logic [1:0]    c_TAG_DISP   = 2'd1;
   localparam logic [1:0]    c_TAG_HOST   = 2'd2;
   localparam logic [AW-1:0] c_LINE_WORDS = AW'(H_ACT >> SCALE_SHIFT);
   localparam logic [AW-1:0] c_FB_WORDS   = AW'(FB_WORDS);
   localparam logic [9:0]    c_V_ACT      = 10'(V_ACT);

   logic          w_disp;
   logic          w_host_win;
   logic          w_host_err;
   logic          w_host_ok;
   logic [AW-1:0] w_disp_addr;
   logic [1:0]    w_tag_next;

   logic [1:0]    r_tag;
   logic [AW-1:0] r_last_addr;
   logic [DW-1:0] r_rgb;
   logic [DW-1:0] r_rdata;
   logic          r_rvalid;
   logic          r_hs_d1, r_hs_d2;
   logic          r_vs_d1, r_vs_d2;
   logic          r_vid_d1, r_vid_d2;
   logic          r_fs_d1, r_fs_d2;

   // Grants are gated by reset so no ack or write escapes while held in reset.
   always_comb begin
      w_disp      = reset & p_tick & video_on;
      w_host_win  = reset & ~w_disp & host_req & (~vblank_only | (pixel_y >= c_V_ACT));
      w_host_err  = w_host_win & (host_addr >= c_FB_WORDS);
      w_host_ok   = w_host_win & ~w_host_err;
      w_disp_addr = AW'(pixel_y >> SCALE_SHIFT) * c_LINE_WORDS + AW'(pixel_x >> SCALE_SHIFT);

      w_tag_next = c_TAG_NONE;
      if (w_disp)
         w_tag_next = c_TAG_DISP;
      else if (w_host_ok && !host_we)
         w_tag_next = c_TAG_HOST;
   end

   always_comb begin
      mem_addr = r_last_addr;
      if (w_disp)
         mem_addr = w_disp_addr;
      else if (w_host_ok)
         mem_addr = host_addr;
   end

   assign mem_we    = w_host_ok & host_we;
   assign mem_wdata = host_wdata;
   assign host_ack  = w_host_win;
   assign host_err  = w_host_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tag       <= c_TAG_NONE;
         r_last_addr <= '0;
         r_rgb       <= '0;
         r_rdata     <= '0;
         r_rvalid    <= 1'b0;
      end else begin
         r_tag    <= w_tag_next;
         r_rvalid <= (r_tag == c_TAG_HOST);
         if (w_disp || w_host_ok)
            r_last_addr <= mem_addr;
         if (r_tag == c_TAG_HOST)
            r_rdata <= mem_rdata;
         if (r_tag == c_TAG_DISP)
            r_rgb <= mem_rdata;
      end
   end

   // Two-stage delay matches the address-to-rgb latency of the RAM path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hs_d1  <= 1'b1;
         r_hs_d2  <= 1'b1;
         r_vs_d1  <= 1'b1;
         r_vs_d2  <= 1'b1;
         r_vid_d1 <= 1'b0;
         r_vid_d2 <= 1'b0;
         r_fs_d1  <= 1'b0;
         r_fs_d2  <= 1'b0;
      end else begin
         r_hs_d1  <= hsync_i;
         r_hs_d2  <= r_hs_d1;
         r_vs_d1  <= vsync_i;
         r_vs_d2  <= r_vs_d1;
         r_vid_d1 <= video_on;
         r_vid_d2 <= r_vid_d1;
         r_fs_d1  <= p_tick & (pixel_x == 10'd0) & (pixel_y == 10'd0);
         r_fs_d2  <= r_fs_d1;
      end
   end

   assign host_rdata  = r_rdata;
   assign host_rvalid = r_rvalid;
   assign hsync       = r_hs_d2;
   assign vsync       = r_vs_d2;
   assign frame_start = r_fs_d2;
   assign rgb         = r_vid_d2 ? r_rgb : '0;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_arbiter
//  Purpose  : Self-checking bench for fb_arbiter with a RAM model and scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_fb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p_tick, video_on, hsync_i, vsync_i, vblank_only;
   logic [9:0]  pixel_x, pixel_y;
   logic        host_req, host_we;
   logic [16:0] host_addr;
   logic [7:0]  host_wdata;
   logic        host_ack, host_rvalid, host_err, mem_we;
   logic [7:0]  host_rdata, mem_wdata, mem_rdata, rgb;
   logic [16:0] mem_addr;
   logic        hsync, vsync, frame_start;

   fb_arbiter dut (
      .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
      .hsync_i(hsync_i), .vsync_i(vsync_i), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .vblank_only(vblank_only), .host_req(host_req), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
      .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_err(host_err),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .hsync(hsync), .vsync(vsync), .rgb(rgb),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   logic [7:0] ram [0:131071];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: kind 0 = rgb, 1 = frame_start pulse, 2 = host read data
   typedef struct {
      int         due;
      int         kind;
      logic [7:0] val;
   } sb_t;
   sb_t sb[$];
   sb_t mon_e;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.due < cyc)
            chk("sb_missed_slot", 32'(cyc), 32'(mon_e.due));
         else if (mon_e.kind == 0)
            chk($sformatf("rgb@%0d", cyc), {24'd0, rgb}, {24'd0, mon_e.val});
         else if (mon_e.kind == 1)
            chk($sformatf("frame_start@%0d", cyc), {31'd0, frame_start}, 32'd1);
         else begin
            chk($sformatf("rvalid@%0d", cyc), {31'd0, host_rvalid}, 32'd1);
            chk($sformatf("rdata@%0d", cyc), {24'd0, host_rdata}, {24'd0, mon_e.val});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One display tick plus one idle pixel-half; rgb expected for both halves.
   task automatic disp_tick(input logic [9:0] x, input logic [9:0] y,
                            input logic [16:0] exp_addr, input logic [7:0] exp_rgb,
                            input logic exp_fs);
      p_tick = 1'b1; video_on = 1'b1; pixel_x = x; pixel_y = y;
      #1;
      chk($sformatf("disp_addr_x%0d_y%0d", x, y), {15'd0, mem_addr}, {15'd0, exp_addr});
      chk("disp_we", {31'd0, mem_we}, 32'd0);
      sb.push_back('{cyc + 2, 0, exp_rgb});
      if (exp_fs) sb.push_back('{cyc + 2, 1, 8'h00});
      sb.push_back('{cyc + 3, 0, exp_rgb});
      step();
      p_tick = 1'b0;
      step();
   endtask

   typedef struct {
      logic        p_tick, video_on, vblank_only;
      logic [9:0]  pixel_x, pixel_y;
      logic        host_req, host_we;
      logic [16:0] host_addr;
      logic        exp_ack, exp_err, exp_we, chk_addr;
      logic [16:0] exp_addr;
   } vec_t;
   vec_t vecs[12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
      ram[0] = 8'hA5; ram[1] = 8'h3C; ram[2] = 8'h5A; ram[5] = 8'h11;

      // Reset asserted mid-frame with busy inputs
      reset = 1'b0; p_tick = 1'b1; video_on = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0;
      pixel_x = 10'd0; pixel_y = 10'd0; vblank_only = 1'b0;
      host_req = 1'b1; host_we = 1'b1; host_addr = 17'd7; host_wdata = 8'h00;
      repeat (3) step();
      chk("rst_rgb", {24'd0, rgb}, 32'd0);
      chk("rst_hsync", {31'd0, hsync}, 32'd1);
      chk("rst_vsync", {31'd0, vsync}, 32'd1);
      chk("rst_ack", {31'd0, host_ack}, 32'd0);
      chk("rst_err", {31'd0, host_err}, 32'd0);
      chk("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
      chk("rst_rdata", {24'd0, host_rdata}, 32'd0);
      chk("rst_fs", {31'd0, frame_start}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);

      p_tick = 1'b0; video_on = 1'b0; host_req = 1'b0;
      reset = 1'b1;
      step();
      chk("hsync_delay1", {31'd0, hsync}, 32'd1);
      step();
      chk("hsync_delay2", {31'd0, hsync}, 32'd0);
      chk("vsync_delay2", {31'd0, vsync}, 32'd0);
      hsync_i = 1'b1; vsync_i = 1'b1;
      step(); step();

      // Pixel replication on line 0
      disp_tick(10'd0, 10'd0, 17'd0, 8'hA5, 1'b1);
      disp_tick(10'd1, 10'd0, 17'd0, 8'hA5, 1'b0);
      disp_tick(10'd2, 10'd0, 17'd1, 8'h3C, 1'b0);
      disp_tick(10'd3, 10'd0, 17'd1, 8'h3C, 1'b0);
      video_on = 1'b0;
      step(); step();
      chk("fs_single_pulse", {31'd0, frame_start}, 32'd0);
      chk("rgb_blank", {24'd0, rgb}, 32'd0);

      // Grant decision table
      vecs[0]  = '{1,1,0, 10'd10,  10'd6,   0,0, 17'd0,      0,0,0, 1, 17'd965};
      vecs[1]  = '{1,1,0, 10'd639, 10'd479, 1,1, 17'd1000,   0,0,0, 1, 17'd76799};
      vecs[2]  = '{0,1,0, 10'd20,  10'd10,  1,1, 17'd1000,   1,0,1, 1, 17'd1000};
      vecs[3]  = '{1,0,0, 10'd700, 10'd300, 1,0, 17'd1001,   1,0,0, 1, 17'd1001};
      vecs[4]  = '{0,0,0, 10'd0,   10'd300, 0,0, 17'd0,      0,0,0, 0, 17'd0};
      vecs[5]  = '{0,0,1, 10'd700, 10'd479, 1,1, 17'd1002,   0,0,0, 0, 17'd0};
      vecs[6]  = '{0,0,1, 10'd0,   10'd480, 1,1, 17'd1002,   1,0,1, 1, 17'd1002};
      vecs[7]  = '{1,0,1, 10'd5,   10'd524, 1,0, 17'd76799,  1,0,0, 1, 17'd76799};
      vecs[8]  = '{0,0,0, 10'd5,   10'd500, 1,1, 17'd76800,  1,1,0, 0, 17'd0};
      vecs[9]  = '{0,0,0, 10'd5,   10'd500, 1,0, 17'd131071, 1,1,0, 0, 17'd0};
      vecs[10] = '{1,1,0, 10'd1,   10'd1,   1,0, 17'd9,      0,0,0, 1, 17'd0};
      vecs[11] = '{0,0,0, 10'd0,   10'd0,   1,0, 17'd3,      1,0,0, 1, 17'd3};
      for (int i = 0; i < 12; i++) begin
         p_tick = vecs[i].p_tick; video_on = vecs[i].video_on;
         vblank_only = vecs[i].vblank_only;
         pixel_x = vecs[i].pixel_x; pixel_y = vecs[i].pixel_y;
         host_req = vecs[i].host_req; host_we = vecs[i].host_we;
         host_addr = vecs[i].host_addr; host_wdata = 8'h00;
         #1;
         chk($sformatf("vec%0d_ack", i), {31'd0, host_ack}, {31'd0, vecs[i].exp_ack});
         chk($sformatf("vec%0d_err", i), {31'd0, host_err}, {31'd0, vecs[i].exp_err});
         chk($sformatf("vec%0d_we", i), {31'd0, mem_we}, {31'd0, vecs[i].exp_we});
         if (vecs[i].chk_addr)
            chk($sformatf("vec%0d_addr", i), {15'd0, mem_addr}, {15'd0, vecs[i].exp_addr});
         step();
      end
      p_tick = 1'b0; video_on = 1'b0; vblank_only = 1'b0; host_req = 1'b0;
      pixel_x = 10'd0; pixel_y = 10'd0;
      repeat (3) step();

      // Host write collides with a display tick, then lands on the next clk
      p_tick = 1'b1; video_on = 1'b1; pixel_x = 10'd4; pixel_y = 10'd0;
      host_req = 1'b1; host_we = 1'b1; host_addr = 17'd320; host_wdata = 8'h7E;
      #1;
      chk("coll_ack", {31'd0, host_ack}, 32'd0);
      chk("coll_we", {31'd0, mem_we}, 32'd0);
      chk("coll_addr", {15'd0, mem_addr}, 32'd2);
      sb.push_back('{cyc + 2, 0, 8'h5A});
      sb.push_back('{cyc + 3, 0, 8'h5A});
      step();
      p_tick = 1'b0;
      #1;
      chk("wr_ack", {31'd0, host_ack}, 32'd1);
      chk("wr_we", {31'd0, mem_we}, 32'd1);
      chk("wr_addr", {15'd0, mem_addr}, 32'd320);
      chk("wr_wdata", {24'd0, mem_wdata}, 32'h7E);
      step();
      host_req = 1'b0;
      disp_tick(10'd0, 10'd2, 17'd320, 8'h7E, 1'b0);
      video_on = 1'b0;
      step(); step();

      // Back-to-back host reads during blanking
      pixel_y = 10'd490; host_req = 1'b1; host_we = 1'b0; host_addr = 17'd5;
      #1;
      chk("rd_ack", {31'd0, host_ack}, 32'd1);
      chk("rd_err", {31'd0, host_err}, 32'd0);
      chk("rd_we", {31'd0, mem_we}, 32'd0);
      chk("rd_addr", {15'd0, mem_addr}, 32'd5);
      sb.push_back('{cyc + 2, 2, 8'h11});
      step();
      host_addr = 17'd0;
      #1;
      chk("rd2_ack", {31'd0, host_ack}, 32'd1);
      sb.push_back('{cyc + 2, 2, 8'hA5});
      step();
      host_req = 1'b0;
      repeat (3) step();

      // vblank_only holds the host off until the vertical blank
      vblank_only = 1'b1; pixel_y = 10'd100; host_req = 1'b1; host_we = 1'b0;
      host_addr = 17'd1;
      for (int i = 0; i < 4; i++) begin
         video_on = (i < 2); p_tick = i[0];
         #1;
         chk($sformatf("vbo_hold%0d", i), {31'd0, host_ack}, 32'd0);
         step();
      end
      video_on = 1'b0; p_tick = 1'b0; pixel_y = 10'd479;
      #1;
      chk("vbo_479", {31'd0, host_ack}, 32'd0);
      step();
      pixel_y = 10'd480;
      #1;
      chk("vbo_480_ack", {31'd0, host_ack}, 32'd1);
      chk("vbo_480_addr", {15'd0, mem_addr}, 32'd1);
      sb.push_back('{cyc + 2, 2, 8'h3C});
      step();
      host_req = 1'b0; vblank_only = 1'b0;
      repeat (3) step();

      // Out-of-range addresses
      host_req = 1'b1; host_we = 1'b1; host_addr = 17'd76800; host_wdata = 8'hFF;
      #1;
      chk("oor_wr_ack", {31'd0, host_ack}, 32'd1);
      chk("oor_wr_err", {31'd0, host_err}, 32'd1);
      chk("oor_wr_we", {31'd0, mem_we}, 32'd0);
      step();
      host_we = 1'b0; host_addr = 17'd100000;
      #1;
      chk("oor_rd_ack", {31'd0, host_ack}, 32'd1);
      chk("oor_rd_err", {31'd0, host_err}, 32'd1);
      step();
      host_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("oor_no_rvalid%0d", i), {31'd0, host_rvalid}, 32'd0);
         step();
      end

      // Reset the cycle after a read ack drops the pending return
      host_req = 1'b1; host_we = 1'b0; host_addr = 17'd5;
      #1;
      chk("rstrd_ack", {31'd0, host_ack}, 32'd1);
      step();
      host_req = 1'b0; reset = 1'b0;
      #1;
      chk("rstrd_rvalid0", {31'd0, host_rvalid}, 32'd0);
      step();
      chk("rstrd_rvalid1", {31'd0, host_rvalid}, 32'd0);
      chk("rstrd_rdata", {24'd0, host_rdata}, 32'd0);
      reset = 1'b1;
      step();
      chk("rstrd_rvalid2", {31'd0, host_rvalid}, 32'd0);
      step();
      chk("rstrd_rvalid3", {31'd0, host_rvalid}, 32'd0);

      repeat (3) step();
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between the display scan-out path, driven by the sync generator's counters, and a host read/write port. Display fetches have absolute priority on active-video pixel ticks. The host gets every other cycle, or only vertical blanking when configured. Outputs pixel data and delayed sync signals aligned to each other for the VGA pins.

Parameters:
DW, 8, framebuffer word / pixel colour width
AW, 17, framebuffer address width
H_ACT, 640, active pixels per line from the sync generator
V_ACT, 480, active lines per frame
SCALE_SHIFT, 1, log2 pixel replication; framebuffer is (H_ACT>>S) x (V_ACT>>S) words
FB_WORDS, 76800, valid framebuffer words, equal to (H_ACT>>S)*(V_ACT>>S)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
p_tick  in  1  pixel enable from sync generator
video_on  in  1  active-region flag
hsync_i  in  1  raw hsync
vsync_i  in  1  raw vsync
pixel_x  in  10  current horizontal count
pixel_y  in  10  current vertical count
vblank_only  in  1  1 = host served only when pixel_y >= V_ACT
host_req  in  1  host request; held with stable fields until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  AW  host word address
host_wdata  in  DW  host write data
host_ack  out  1  request accepted (one-cycle pulse)
host_rdata  out  DW  host read data
host_rvalid  out  1  host_rdata valid (one-cycle pulse)
host_err  out  1  address out of range (pulses with host_ack)
mem_addr  out  AW  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data; valid one clk after address is presented
hsync  out  1  hsync_i delayed 2 clk
vsync  out  1  vsync_i delayed 2 clk
rgb  out  DW  pixel colour; 0 outside active video
frame_start  out  1  pulse on p_tick at pixel (0,0), aligned with rgb

Behaviour:
- Reset (reset=0, async): host_ack=0, host_rvalid=0, host_err=0, host_rdata=0, rgb=0, hsync=1, vsync=1, frame_start=0, mem_we=0. Return-tag state = NONE. Delay pipes are loaded with hsync=1, vsync=1, video_on=0.
- Per-cycle grant (combinational, decided in cycle N):
  - DISP if p_tick & video_on.
  - Else HOST if host_req & (!vblank_only | pixel_y >= V_ACT).
  - Else IDLE.
- DISP: mem_addr = (pixel_y>>S)*(H_ACT>>S) + (pixel_x>>S), mem_we=0. Return tag = DISP.
- HOST, addr < FB_WORDS:
  - host_ack=1 in cycle N.
  - Write: mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata. Return tag = NONE.
  - Read: mem_we=0. Return tag = HOST.
- HOST, addr >= FB_WORDS: host_ack=1 and host_err=1 in cycle N. No RAM access, mem_we=0, no rvalid.
- IDLE: mem_we=0, mem_addr holds its last value. Return tag = NONE.
- Return tag is registered, with states NONE / DISP / HOST:
  - DISP in N+1: rgb <= mem_rdata at end of N+1.
  - HOST in N+1: host_rdata <= mem_rdata; host_rvalid=1 in cycle N+2 for one clk.
- rgb is forced to 0 when the 2-clk-delayed video_on is 0. rgb holds its value between ticks.
- hsync, vsync and video_on pass through a 2-stage shift register every clk, so they align with rgb. With p_tick every 2 clk, rgb is stable for a full pixel period.
- Host throughput:
  - Active video with p_tick every other clk: at most one access per 2 clk.
  - Blanking: one access per clk.
  - host_req held across an ack is a new request; the host must drop req or change fields in the cycle after ack.
- Simultaneous p_tick in the active region and host_req: the display wins. The host is not acked, keeps req, and is served next free cycle.
- Reset mid-read: the pending tag is cleared and no host_rvalid is produced.
- Address arithmetic is unsigned; the result is always < FB_WORDS for active coordinates.

Test Plan:
- Reset with reset=0 mid-frame, then release -> rgb=0, hsync=vsync=1, host_ack=0. The first p_tick at (0,0) gives frame_start=1 two clk later.
- Preload mem[0]=8'hA5, mem[1]=8'h3C, S=1. p_tick at x=0,1,2,3 on y=0 -> mem_addr 0,0,1,1. rgb = A5,A5,3C,3C, each 2 clk after its tick.
- Host write addr=320, data=8'h7E, issued during active video on a p_tick cycle -> no ack that cycle; ack with mem_we=1 next clk. Display of pixel (0,2) then shows 7E.
- Host read addr=5 with mem[5]=8'h11 during blanking -> ack at N, host_rvalid=1 with host_rdata=11 at N+2.
- vblank_only=1, host_req on line 100 -> no ack until pixel_y reaches 480, then ack within 1 clk.
- Host write addr=76800 -> host_ack=1, host_err=1, mem_we stays 0. Reset asserted the cycle after a host read ack -> no host_rvalid.
